fios_pe_seq: RTL and testbench

//  Sequencer for one FIOS Montgomery PE built around a single DSP slice.
//  On start_i it runs NWORDS outer iterations; each iteration is a_i*B + t, then m = t0*p'0, then m*P.
//  It drives all PE control: mux selects, OPMODE, register enables, and the a/b/p word indices.
//  It sits between the top-level multiplier FSM and the PE; the PE registers every control it receives.

---
 rtl/fios_seq_pkg.sv | 42 ++++
 rtl/delay_line.sv | 30 +++
 rtl/fios_pe_seq.sv | 196 +++++++++++++++++++
 tb/tb_fios_pe_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fios_seq_pkg.sv
// Shared types and constants for the FIOS Montgomery PE sequencer.
// Holds the state enum, DSP OPMODE words, PE mux select codes and the latency helper.
package fios_seq_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_LOAD,
      S_AB0,
      S_WAIT_T,
      S_MUL_M,
      S_WAIT_M,
      S_MP0,
      S_AB_J,
      S_MP_J,
      S_DRAIN,
      S_DONE
   } seq_state_t;

   localparam logic [6:0] OP_ZERO  = 7'b000_00_00;
   localparam logic [6:0] OP_MUL   = 7'b000_01_01;
   localparam logic [6:0] OP_MAC_C = 7'b011_01_01;
   localparam logic [6:0] OP_MAC_P = 7'b010_01_01;

   localparam logic [1:0] MUXA_AREG = 2'd0;
   localparam logic [1:0] MUXA_RES  = 2'd1;
   localparam logic [1:0] MUXA_MREG = 2'd2;
   localparam logic [1:0] MUXA_ZERO = 2'd3;

   localparam logic [1:0] MUXB_B    = 2'd0;
   localparam logic [1:0] MUXB_P0   = 2'd1;
   localparam logic [1:0] MUXB_P    = 2'd2;
   localparam logic [1:0] MUXB_ZERO = 2'd3;

   localparam logic [1:0] MUXC_CI   = 2'd0;
   localparam logic [1:0] MUXC_RESD = 2'd1;

   // Cycles from a product being presented to the DSP until its result is on RES.
   function automatic int unsigned LAT(input int unsigned abreg, input int unsigned mreg);
      return 1 + abreg + mreg;
   endfunction

endpackage

// File: rtl/delay_line.sv
// Fixed-length register delay line with asynchronous reset.
// Output equals the input sampled DELAY clock edges earlier.
module delay_line #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned DELAY = 1
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] pipe [DELAY];

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         for (int unsigned k = 0; k < DELAY; k++) begin
            pipe[k] <= '0;
         end
      end else begin
         pipe[0] <= d_i;
         for (int unsigned k = 1; k < DELAY; k++) begin
            pipe[k] <= pipe[k-1];
         end
      end
   end

   assign q_o = pipe[DELAY-1];

endmodule

// File: rtl/fios_pe_seq.sv
// Control sequencer for one FIOS Montgomery PE built on a single DSP slice.
// Per outer word a_i it issues a_i*B + t, m = t0*p'0, then m*P, and flags final result words.
module fios_pe_seq
   import fios_seq_pkg::*;
#(
   parameter int unsigned NWORDS = 4,
   parameter int unsigned ABREG  = 1,
   parameter int unsigned MREG   = 1,
   parameter int unsigned CREG   = 1,
   localparam int unsigned IW    = $clog2(NWORDS)
) (
   input  logic          clock_i,
   input  logic          reset_i,
   input  logic          start_i,
   output logic          busy_o,
   output logic          done_o,
   output logic [IW-1:0] a_idx_o,
   output logic [IW-1:0] b_idx_o,
   output logic          a_reg_en_o,
   output logic          m_reg_en_o,
   output logic [1:0]    mux_A_sel_o,
   output logic [1:0]    mux_B_sel_o,
   output logic [1:0]    mux_C_sel_o,
   output logic          CREG_en_o,
   output logic [6:0]    OPMODE_o,
   output logic          RES_delay_en_o,
   output logic          res_valid_o,
   output logic [IW-1:0] res_idx_o
);

   localparam int unsigned LAT_C = LAT(ABREG, MREG);
   localparam int unsigned WW    = (LAT_C > 1) ? $clog2(LAT_C) : 1;
   localparam logic [WW-1:0] W_T = WW'((LAT_C >= 2) ? LAT_C - 2 : 0);
   localparam logic [WW-1:0] W_M = WW'(LAT_C - 1);
   localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

   seq_state_t    state, state_n;
   logic [IW-1:0] i_q, i_n;
   logic [IW-1:0] j_q, j_n;
   logic [WW-1:0] w_q, w_n;
   logic [IW:0]   dl_d, dl_q;

   always_comb begin
      state_n = state;
      i_n     = i_q;
      j_n     = j_q;
      w_n     = w_q;
      case (state)
         S_IDLE: begin
            if (start_i) begin
               state_n = S_LOAD;
               i_n     = '0;
               j_n     = '0;
            end
         end
         S_LOAD: state_n = S_AB0;
         S_AB0: begin
            // With LAT==1 there is no wait between the a*B issue and reading t back.
            if (LAT_C > 1) begin
               state_n = S_WAIT_T;
               w_n     = W_T;
            end else begin
               state_n = S_MUL_M;
            end
         end
         S_WAIT_T: begin
            if (w_q == '0) state_n = S_MUL_M;
            else           w_n     = w_q - 1'b1;
         end
         S_MUL_M: begin
            state_n = S_WAIT_M;
            w_n     = W_M;
         end
         S_WAIT_M: begin
            if (w_q == '0) state_n = S_MP0;
            else           w_n     = w_q - 1'b1;
         end
         S_MP0: begin
            state_n = S_AB_J;
            j_n     = IW'(1);
         end
         S_AB_J: state_n = S_MP_J;
         S_MP_J: begin
            if (j_q == LAST) begin
               j_n = '0;
               if (i_q == LAST) begin
                  state_n = S_DRAIN;
                  w_n     = W_M;
               end else begin
                  i_n     = i_q + 1'b1;
                  state_n = S_LOAD;
               end
            end else begin
               j_n     = j_q + 1'b1;
               state_n = S_AB_J;
            end
         end
         S_DRAIN: begin
            if (w_q == '0) state_n = S_DONE;
            else           w_n     = w_q - 1'b1;
         end
         S_DONE: begin
            state_n = S_IDLE;
            i_n     = '0;
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Result flags enter the delay line on the edge that issues MP_J (word j-1)
   // and on the edge entering DRAIN (top word NWORDS-1), last outer iteration only.
   always_comb begin
      dl_d = '0;
      if (state_n == S_MP_J && i_n == LAST) begin
         dl_d = {1'b1, j_n - 1'b1};
      end else if (state_n == S_DRAIN && state == S_MP_J) begin
         dl_d = {1'b1, LAST};
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state          <= S_IDLE;
         i_q            <= '0;
         j_q            <= '0;
         w_q            <= '0;
         busy_o         <= 1'b0;
         done_o         <= 1'b0;
         a_idx_o        <= '0;
         b_idx_o        <= '0;
         a_reg_en_o     <= 1'b0;
         m_reg_en_o     <= 1'b0;
         mux_A_sel_o    <= MUXA_ZERO;
         mux_B_sel_o    <= MUXB_ZERO;
         mux_C_sel_o    <= MUXC_CI;
         CREG_en_o      <= 1'b0;
         OPMODE_o       <= OP_ZERO;
         RES_delay_en_o <= 1'b0;
      end else begin
         state          <= state_n;
         i_q            <= i_n;
         j_q            <= j_n;
         w_q            <= w_n;
         busy_o         <= (state_n != S_IDLE) && (state_n != S_DONE);
         done_o         <= (state_n == S_DONE);
         a_idx_o        <= i_n;
         b_idx_o        <= j_n;
         a_reg_en_o     <= (state_n == S_LOAD);
         m_reg_en_o     <= (state_n == S_WAIT_M) && (w_n == '0);
         CREG_en_o      <= (state_n == S_AB0) && (CREG != 0);
         RES_delay_en_o <= (state_n == S_MUL_M);
         mux_A_sel_o    <= MUXA_ZERO;
         mux_B_sel_o    <= MUXB_ZERO;
         mux_C_sel_o    <= MUXC_CI;
         OPMODE_o       <= OP_ZERO;
         case (state_n)
            S_AB0: begin
               mux_A_sel_o <= MUXA_AREG;
               mux_B_sel_o <= MUXB_B;
               OPMODE_o    <= OP_MAC_C;
            end
            S_MUL_M: begin
               mux_A_sel_o <= MUXA_RES;
               mux_B_sel_o <= MUXB_P0;
               OPMODE_o    <= OP_MUL;
            end
            S_MP0, S_MP_J: begin
               mux_A_sel_o <= MUXA_MREG;
               mux_B_sel_o <= MUXB_P;
               mux_C_sel_o <= MUXC_RESD;
               OPMODE_o    <= OP_MAC_C;
            end
            S_AB_J: begin
               mux_A_sel_o <= MUXA_AREG;
               mux_B_sel_o <= MUXB_B;
               OPMODE_o    <= OP_MAC_P;
            end
            default: ;
         endcase
      end
   end

   delay_line #(
      .WIDTH (IW + 1),
      .DELAY (LAT_C + 1)
   ) u_res_dly (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .d_i     (dl_d),
      .q_o     (dl_q)
   );

   assign res_valid_o = dl_q[IW];
   assign res_idx_o   = dl_q[IW-1:0];

endmodule

// File: tb/tb_fios_pe_seq.sv
// Bench for fios_pe_seq: a per-cycle schedule model built from the iteration recipe,
// compared every cycle against a default instance and a LAT=1, NWORDS=2 instance.
module tb_fios_pe_seq;

   typedef struct {
      int busy; int done; int aidx; int bidx; int aen; int men; int ma;
      int mb; int mc; int cen; int op; int rden; int rv; int ridx;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst0, rst1, start0, start1;

   logic       busy0, done0, aen0, men0, cen0, rden0, rv0;
   logic [1:0] aidx0, bidx0, ridx0, ma0, mb0, mc0;
   logic [6:0] op0;

   logic       busy1, done1, aen1, men1, cen1, rden1, rv1;
   logic [0:0] aidx1, bidx1, ridx1;
   logic [1:0] ma1, mb1, mc1;
   logic [6:0] op1;

   fios_pe_seq #(.NWORDS(4), .ABREG(1), .MREG(1), .CREG(1)) dut0 (
      .clock_i(clk), .reset_i(rst0), .start_i(start0), .busy_o(busy0), .done_o(done0),
      .a_idx_o(aidx0), .b_idx_o(bidx0), .a_reg_en_o(aen0), .m_reg_en_o(men0),
      .mux_A_sel_o(ma0), .mux_B_sel_o(mb0), .mux_C_sel_o(mc0), .CREG_en_o(cen0),
      .OPMODE_o(op0), .RES_delay_en_o(rden0), .res_valid_o(rv0), .res_idx_o(ridx0)
   );

   fios_pe_seq #(.NWORDS(2), .ABREG(0), .MREG(0), .CREG(1)) dut1 (
      .clock_i(clk), .reset_i(rst1), .start_i(start1), .busy_o(busy1), .done_o(done1),
      .a_idx_o(aidx1), .b_idx_o(bidx1), .a_reg_en_o(aen1), .m_reg_en_o(men1),
      .mux_A_sel_o(ma1), .mux_B_sel_o(mb1), .mux_C_sel_o(mc1), .CREG_en_o(cen1),
      .OPMODE_o(op1), .RES_delay_en_o(rden1), .res_valid_o(rv1), .res_idx_o(ridx1)
   );

   exp_t tr[$];
   exp_t q0[$];
   exp_t q1[$];
   int   n_checks = 0;
   int   n_err    = 0;
   bit   chk_en   = 1'b0;

   function automatic exp_t idle_e();
      exp_t e;
      e.busy = 0; e.done = 0; e.aidx = 0; e.bidx = 0; e.aen = 0; e.men = 0;
      e.ma = 3; e.mb = 3; e.mc = 0; e.cen = 0; e.op = 0; e.rden = 0; e.rv = 0; e.ridx = 0;
      return e;
   endfunction

   function automatic exp_t base_e(input int i);
      exp_t e;
      e = idle_e();
      e.busy = 1;
      e.aidx = i;
      return e;
   endfunction

   // Expected outputs for cycles 1..end of one run, straight from the iteration recipe.
   task automatic build(input int n, input int lat);
      exp_t e;
      int   rpos[$];
      int   rix[$];
      tr.delete();
      for (int i = 0; i < n; i++) begin
         e = base_e(i); e.aen = 1; tr.push_back(e);
         e = base_e(i); e.ma = 0; e.mb = 0; e.mc = 0; e.cen = 1; e.op = 'h35; tr.push_back(e);
         for (int k = 0; k < lat - 1; k++) tr.push_back(base_e(i));
         e = base_e(i); e.ma = 1; e.mb = 1; e.op = 'h05; e.rden = 1; tr.push_back(e);
         for (int k = 0; k < lat; k++) begin
            e = base_e(i); e.men = (k == lat - 1) ? 1 : 0; tr.push_back(e);
         end
         e = base_e(i); e.ma = 2; e.mb = 2; e.mc = 1; e.op = 'h35; tr.push_back(e);
         for (int j = 1; j < n; j++) begin
            e = base_e(i); e.ma = 0; e.mb = 0; e.op = 'h25; e.bidx = j; tr.push_back(e);
            e = base_e(i); e.ma = 2; e.mb = 2; e.mc = 1; e.op = 'h35; e.bidx = j; tr.push_back(e);
            if (i == n - 1) begin
               rpos.push_back(tr.size() - 1);
               rix.push_back(j - 1);
            end
         end
      end
      rpos.push_back(tr.size());
      rix.push_back(n - 1);
      for (int k = 0; k < lat; k++) tr.push_back(base_e(n - 1));
      e = base_e(n - 1); e.busy = 0; e.done = 1; tr.push_back(e);
      for (int r = 0; r < rpos.size(); r++) begin
         e = tr[rpos[r] + lat];
         e.rv = 1;
         e.ridx = rix[r];
         tr[rpos[r] + lat] = e;
      end
   endtask

   task automatic chk(input string name, input int act, input int want);
      n_checks++;
      if (act != want) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, want);
      end
   endtask

   task automatic cmp(input string tag, input exp_t a, input exp_t e);
      chk({tag, ".busy"}, a.busy, e.busy);
      chk({tag, ".done"}, a.done, e.done);
      chk({tag, ".a_idx"}, a.aidx, e.aidx);
      chk({tag, ".b_idx"}, a.bidx, e.bidx);
      chk({tag, ".a_reg_en"}, a.aen, e.aen);
      chk({tag, ".m_reg_en"}, a.men, e.men);
      chk({tag, ".mux_A"}, a.ma, e.ma);
      chk({tag, ".mux_B"}, a.mb, e.mb);
      chk({tag, ".mux_C"}, a.mc, e.mc);
      chk({tag, ".CREG_en"}, a.cen, e.cen);
      chk({tag, ".OPMODE"}, a.op, e.op);
      chk({tag, ".RES_delay_en"}, a.rden, e.rden);
      chk({tag, ".res_valid"}, a.rv, e.rv);
      chk({tag, ".res_idx"}, a.ridx, e.ridx);
   endtask

   exp_t a0, a1, e0, e1;

   always @(negedge clk) begin
      if (chk_en) begin
         if (q0.size() > 0) e0 = q0.pop_front();
         else               e0 = idle_e();
         if (q1.size() > 0) e1 = q1.pop_front();
         else               e1 = idle_e();
         a0.busy = int'(busy0); a0.done = int'(done0); a0.aidx = int'(aidx0);
         a0.bidx = int'(bidx0); a0.aen = int'(aen0); a0.men = int'(men0);
         a0.ma = int'(ma0); a0.mb = int'(mb0); a0.mc = int'(mc0); a0.cen = int'(cen0);
         a0.op = int'(op0); a0.rden = int'(rden0); a0.rv = int'(rv0); a0.ridx = int'(ridx0);
         a1.busy = int'(busy1); a1.done = int'(done1); a1.aidx = int'(aidx1);
         a1.bidx = int'(bidx1); a1.aen = int'(aen1); a1.men = int'(men1);
         a1.ma = int'(ma1); a1.mb = int'(mb1); a1.mc = int'(mc1); a1.cen = int'(cen1);
         a1.op = int'(op1); a1.rden = int'(rden1); a1.rv = int'(rv1); a1.ridx = int'(ridx1);
         cmp("dut0", a0, e0);
         cmp("dut1", a1, e1);
      end
   end

   task automatic check_model();
      int busy_n;
      int apos[$];
      build(4, 3);
      chk("model.len64", tr.size(), 64);
      chk("model.done_at_64", tr[63].done, 1);
      busy_n = 0;
      for (int k = 0; k < tr.size(); k++) begin
         busy_n += tr[k].busy;
         if (tr[k].aen == 1) apos.push_back(k);
      end
      chk("model.busy_63", busy_n, 63);
      chk("model.aen_count", apos.size(), 4);
      for (int k = 0; k < apos.size(); k++) chk("model.aen_spacing", apos[k], 15 * k);
      chk("model.c2_opmode", tr[1].op, 'h35);
      chk("model.c5_mul_m", tr[4].rden, 1);
      chk("model.c8_m_en", tr[7].men, 1);
      chk("model.c9_mp0", tr[8].ma, 2);
      build(2, 1);
      chk("model.len16", tr.size(), 16);
      chk("model.rv_first", tr[14].rv, 1);
      chk("model.ridx_first", tr[14].ridx, 0);
      chk("model.rv_second", tr[15].rv, 1);
      chk("model.ridx_second", tr[15].ridx, 1);
   endtask

   task automatic launch(input int which);
      @(posedge clk); #1;
      if (which == 0) start0 = 1'b1; else start1 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      start1 = 1'b0;
      if (which == 0) begin build(4, 3); q0 = tr; end
      else            begin build(2, 1); q1 = tr; end
   endtask

   task automatic wait_done(input int which, input int want, input bit glitch, input string name);
      int found;
      found = -1;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         if (glitch) start0 = (c == 10 || c == 30) ? 1'b1 : 1'b0;
         if (((which == 0) ? done0 : done1) === 1'b1) begin
            found = c;
            break;
         end
      end
      start0 = 1'b0;
      chk(name, found, want);
   endtask

   initial begin
      rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b0; start1 = 1'b0;
      chk_en = 1'b1;
      check_model();
      repeat (3) @(posedge clk);
      #1 rst0 = 1'b0; rst1 = 1'b0;

      launch(0);
      wait_done(0, 64, 1'b1, "done_latency_default");
      repeat (3) @(posedge clk);

      // Abort a run with reset in cycle 20; the model then expects idle outputs.
      launch(0);
      for (int c = 1; c <= 19; c++) @(negedge clk);
      @(posedge clk); #1;
      rst0 = 1'b1;
      q0.delete();
      repeat (2) @(posedge clk);
      #1 rst0 = 1'b0;
      begin
         int dn;
         dn = 0;
         for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if (done0 === 1'b1) dn++;
         end
         chk("no_done_after_reset", dn, 0);
      end

      launch(0);
      wait_done(0, 64, 1'b0, "done_latency_after_reset");
      launch(1);
      wait_done(1, 16, 1'b0, "done_latency_lat1_n2");
      repeat (4) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
